// File: rtl/vt100_pkg.sv
// vt100_pkg
// Types and constants shared by the VT100 report encoder and its digit
// converter: the report type enum, the encoder state enum, and the fixed
// bytes and strings that make up terminal-to-host sequences.
package vt100_pkg;

  typedef enum logic [2:0] {
    REPORT_CPR,
    REPORT_DA,
    REPORT_OK,
    REPORT_KEY_UP,
    REPORT_KEY_DOWN,
    REPORT_KEY_RIGHT,
    REPORT_KEY_LEFT
  } ReportType_t;

  typedef enum logic [2:0] {
    IDLE,
    CONVERT,
    EMIT,
    GUARD,
    WAIT
  } EncState_t;

  localparam logic [7:0] ASCII_ESC      = 8'h1B;
  localparam logic [7:0] ASCII_LBRACKET = 8'h5B;
  localparam logic [7:0] ASCII_SEMI     = 8'h3B;
  localparam logic [7:0] ASCII_CPR_END  = 8'h52;

  // Device Attributes answer "ESC [ ? 1 ; 0 c", first byte in the top bits.
  localparam int         DA_LEN    = 7;
  localparam logic [55:0] DA_STRING = 56'h1B5B3F313B3063;

  // Byte idx of the DA answer.
  function automatic logic [7:0] da_byte(input logic [3:0] idx);
    logic [7:0] b;
    b = DA_STRING[7:0];
    for (int i = 0; i < DA_LEN; i++) begin
      if (idx == 4'(i)) b = DA_STRING[8*(DA_LEN-1-i) +: 8];
    end
    return b;
  endfunction

  // ASCII digit k (0 = most significant) of a number whose decimal form
  // has n digits h t u with leading zeros already stripped.
  function automatic logic [7:0] digit_char(input logic [3:0] h,
                                            input logic [3:0] t,
                                            input logic [3:0] u,
                                            input logic [1:0] n,
                                            input logic [3:0] k);
    logic [3:0] d;
    d = u;
    case (n)
      2'd3:    d = (k == 4'd0) ? h : ((k == 4'd1) ? t : u);
      2'd2:    d = (k == 4'd0) ? t : u;
      default: d = u;
    endcase
    return {4'h3, d};
  endfunction

endpackage

// File: rtl/vt100_decimal_digits.sv
// vt100_decimal_digits
// Sequential binary-to-decimal converter using repeated subtraction of 100
// and then 10. One conversion per start pulse; done pulses for one cycle when
// the digits are valid, and the digit outputs hold until the next conversion.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           begin converting value (ignored while a conversion runs)
//   value           unsigned number to convert (at most three decimal digits)
//   done            one-cycle pulse: hundreds/tens/units/count are valid
//   hundreds, tens, units  BCD digits
//   count           number of significant digits (1..3)
module vt100_decimal_digits #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  output logic             done,
  output logic [3:0]       hundreds,
  output logic [3:0]       tens,
  output logic [3:0]       units,
  output logic [1:0]       count
);

  // The remainder is at least 8 bits so the constant 100 always fits.
  localparam int RW = (WIDTH < 8) ? 8 : WIDTH;

  typedef enum logic [1:0] {
    CV_IDLE,
    CV_HUND,
    CV_TENS
  } ConvPhase_t;

  ConvPhase_t phase, next_phase;
  logic [RW-1:0] rem;
  logic [3:0]    h_cnt, t_cnt;

  always_ff @(posedge clk) begin
    if (rst) phase <= CV_IDLE;
    else     phase <= next_phase;
  end

  // Each phase keeps subtracting until the remainder drops below its weight.
  always_comb begin
    next_phase = phase;
    case (phase)
      CV_IDLE: if (start) next_phase = CV_HUND;
      CV_HUND: if (rem < RW'(100)) next_phase = CV_TENS;
      CV_TENS: if (rem < RW'(10)) next_phase = CV_IDLE;
      default: next_phase = CV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem      <= '0;
      h_cnt    <= '0;
      t_cnt    <= '0;
      done     <= 1'b0;
      hundreds <= '0;
      tens     <= '0;
      units    <= '0;
      count    <= 2'd1;
    end else begin
      done <= 1'b0;
      case (phase)
        CV_IDLE: begin
          if (start) begin
            rem   <= RW'(value);
            h_cnt <= '0;
            t_cnt <= '0;
          end
        end
        CV_HUND: begin
          if (rem >= RW'(100)) begin
            rem   <= rem - RW'(100);
            h_cnt <= h_cnt + 4'd1;
          end
        end
        CV_TENS: begin
          if (rem >= RW'(10)) begin
            rem   <= rem - RW'(10);
            t_cnt <= t_cnt + 4'd1;
          end else begin
            hundreds <= h_cnt;
            tens     <= t_cnt;
            units    <= rem[3:0];
            count    <= (h_cnt != 4'd0) ? 2'd3 : ((t_cnt != 4'd0) ? 2'd2 : 2'd1);
            done     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/vt100_report_encoder.sv
// vt100_report_encoder
// Terminal-to-host encoder for the VT100 link. Turns report requests (CPR,
// DA, OK, cursor keys) and plain ASCII key bytes into byte sequences and
// feeds them one at a time to the UART async_transmitter via start/busy.
// Optional build macro: VT100_KEY_FIFO_EN adds a FIFO_DEPTH-entry key queue
// so key bytes are accepted while a sequence is in flight.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   reqValid/reqReady        report request handshake
//   reqType, reqRow, reqCol  report kind and 0-based cursor position (CPR)
//   keyValid/keyReady        plain key handshake, keyData is the byte
//   txBusy                   transmitter busy
//   txStart, txData          one-cycle send pulse and the byte to send
//   active                   a sequence or queued key is pending
module vt100_report_encoder
  import vt100_pkg::*;
#(
  parameter int COORD_WIDTH = 7,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   reqValid,
  input  ReportType_t            reqType,
  input  logic [COORD_WIDTH-1:0] reqRow,
  input  logic [COORD_WIDTH-1:0] reqCol,
  output logic                   reqReady,
  input  logic                   keyValid,
  input  logic [7:0]             keyData,
  output logic                   keyReady,
  input  logic                   txBusy,
  output logic                   txStart,
  output logic [7:0]             txData,
  output logic                   active
);

  // Reports are 1-based, so coordinates grow by one bit.
  localparam int VW = COORD_WIDTH + 1;

  EncState_t   state, next_state;
  ReportType_t type_q;
  logic        plain_q;
  logic [7:0]  key_q;
  logic [VW-1:0] row_q, col_q;
  logic [3:0]  row_h, row_t, row_u, col_h, col_t, col_u;
  logic [1:0]  row_n, col_n;
  logic [3:0]  idx_q, seq_len, row_end, col_end;
  logic [7:0]  cur_byte, tx_data_q, key_src;
  logic        conv_start, conv_col, conv_done;
  logic [3:0]  cv_h, cv_t, cv_u;
  logic [1:0]  cv_n;
  logic        req_acc, key_take, last_byte, tx_start_c, queue_pending;

`ifdef VT100_KEY_FIFO_EN
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] fifo_cnt;
  logic        fifo_full, fifo_empty, fifo_push;

  assign fifo_full     = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty    = (fifo_cnt == '0);
  assign fifo_push     = keyValid && keyReady;
  assign key_src       = fifo_mem[rd_ptr];
  assign queue_pending = !fifo_empty;

  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[wr_ptr] <= keyData;
  end

  // keyReady is low while full, so push and pop never meet on a full queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
      if (key_take)  rd_ptr <= rd_ptr + 1'b1;
      case ({fifo_push, key_take})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: ;
      endcase
    end
  end
`else
  assign key_src       = keyData;
  assign queue_pending = 1'b0;
`endif

  vt100_decimal_digits #(
    .WIDTH (VW)
  ) u_digits (
    .clk      (clk),
    .rst      (rst),
    .start    (conv_start),
    .value    (conv_col ? col_q : row_q),
    .done     (conv_done),
    .hundreds (cv_h),
    .tens     (cv_t),
    .units    (cv_u),
    .count    (cv_n)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Handshake outputs are forced low during reset so the reset cycle itself
  // shows txStart=0 and no readiness, whatever state is being left.
  always_comb begin
    next_state = state;
    tx_start_c = 1'b0;
    reqReady   = !rst && (state == IDLE);
    req_acc    = reqValid && reqReady;
`ifdef VT100_KEY_FIFO_EN
    keyReady   = !rst && !fifo_full;
    key_take   = reqReady && !reqValid && !fifo_empty;
`else
    keyReady   = reqReady && !reqValid;
    key_take   = keyValid && keyReady;
`endif
    case (state)
      IDLE: begin
        if (req_acc)       next_state = (reqType == REPORT_CPR) ? CONVERT : EMIT;
        else if (key_take) next_state = EMIT;
      end
      CONVERT: if (conv_done && conv_col) next_state = EMIT;
      EMIT: begin
        if (!txBusy) begin
          tx_start_c = 1'b1;
          next_state = GUARD;
        end
      end
      GUARD: next_state = WAIT;
      WAIT: begin
        if (!txBusy) next_state = last_byte ? IDLE : EMIT;
      end
      default: next_state = IDLE;
    endcase
  end

  assign txStart = tx_start_c && !rst;
  assign txData  = (state == EMIT && !rst) ? cur_byte : tx_data_q;
  assign active  = !rst && ((state != IDLE) || queue_pending);

  // Current byte and sequence length from the latched request. CPR layout:
  // ESC [ <row digits> ; <col digits> R, so ';' sits at row_end and 'R' at
  // col_end.
  always_comb begin
    seq_len  = 4'd1;
    cur_byte = key_q;
    row_end  = 4'd2 + {2'b00, row_n};
    col_end  = row_end + 4'd1 + {2'b00, col_n};
    if (!plain_q) begin
      case (type_q)
        REPORT_CPR: begin
          seq_len = col_end + 4'd1;
          if (idx_q == 4'd0)          cur_byte = ASCII_ESC;
          else if (idx_q == 4'd1)     cur_byte = ASCII_LBRACKET;
          else if (idx_q < row_end)   cur_byte = digit_char(row_h, row_t, row_u, row_n, idx_q - 4'd2);
          else if (idx_q == row_end)  cur_byte = ASCII_SEMI;
          else if (idx_q < col_end)   cur_byte = digit_char(col_h, col_t, col_u, col_n, idx_q - row_end - 4'd1);
          else                        cur_byte = ASCII_CPR_END;
        end
        REPORT_DA: begin
          seq_len  = 4'(DA_LEN);
          cur_byte = da_byte(idx_q);
        end
        REPORT_OK: begin
          seq_len = 4'd4;
          case (idx_q)
            4'd0:    cur_byte = ASCII_ESC;
            4'd1:    cur_byte = ASCII_LBRACKET;
            4'd2:    cur_byte = 8'h30;
            default: cur_byte = 8'h6E;
          endcase
        end
        default: begin
          seq_len = 4'd3;
          case (idx_q)
            4'd0: cur_byte = ASCII_ESC;
            4'd1: cur_byte = ASCII_LBRACKET;
            default: begin
              case (type_q)
                REPORT_KEY_UP:    cur_byte = 8'h41;
                REPORT_KEY_DOWN:  cur_byte = 8'h42;
                REPORT_KEY_RIGHT: cur_byte = 8'h43;
                default:          cur_byte = 8'h44;
              endcase
            end
          endcase
        end
      endcase
    end
  end

  assign last_byte = (idx_q == seq_len - 4'd1);

  // Request/key capture, CPR digit conversion (row first, then column),
  // byte index stepping and the held copy of the last byte sent.
  always_ff @(posedge clk) begin
    if (rst) begin
      type_q     <= REPORT_CPR;
      plain_q    <= 1'b0;
      key_q      <= '0;
      row_q      <= '0;
      col_q      <= '0;
      idx_q      <= '0;
      tx_data_q  <= '0;
      conv_start <= 1'b0;
      conv_col   <= 1'b0;
      row_h      <= '0;
      row_t      <= '0;
      row_u      <= '0;
      row_n      <= 2'd1;
      col_h      <= '0;
      col_t      <= '0;
      col_u      <= '0;
      col_n      <= 2'd1;
    end else begin
      conv_start <= 1'b0;
      if (req_acc) begin
        type_q  <= reqType;
        plain_q <= 1'b0;
        row_q   <= VW'(reqRow) + VW'(1);
        col_q   <= VW'(reqCol) + VW'(1);
        idx_q   <= '0;
        if (reqType == REPORT_CPR) begin
          conv_start <= 1'b1;
          conv_col   <= 1'b0;
        end
      end else if (key_take) begin
        plain_q <= 1'b1;
        key_q   <= key_src;
        idx_q   <= '0;
      end
      if (state == CONVERT && conv_done) begin
        if (!conv_col) begin
          row_h      <= cv_h;
          row_t      <= cv_t;
          row_u      <= cv_u;
          row_n      <= cv_n;
          conv_col   <= 1'b1;
          conv_start <= 1'b1;
        end else begin
          col_h <= cv_h;
          col_t <= cv_t;
          col_u <= cv_u;
          col_n <= cv_n;
        end
      end
      if (tx_start_c) tx_data_q <= cur_byte;
      if (state == WAIT && !txBusy && !last_byte) idx_q <= idx_q + 4'd1;
    end
  end

endmodule

// File: doc/vt100_report_encoder.md
Name: vt100_report_encoder

Overview:
- Terminal-to-host direction of the VT100 link; counterpart of the VT100 parser, which decodes host-to-terminal bytes.
- Encodes terminal reports and keyboard input into byte sequences: Cursor Position Report, Device Attributes, Status OK, cursor keys, and plain ASCII.
- Drives the UART async_transmitter one byte at a time using its start/busy handshake.
- Sits between the parser/keyboard path and uartTransmitter. It replaces the direct scan_code_ready-to-uartStartSend connection.

Parameters:
- COORD_WIDTH, 7, width of the row and column inputs. Values are 0-based; the maximum encodable value is 2^COORD_WIDTH-1, and at most three decimal digits are ever needed.
- FIFO_DEPTH, 4, depth of the key-byte queue. Used only when VT100_KEY_FIFO_EN is defined; must be a power of two.

Ports:
- clk  input  1  system clock, same domain as the UART modules.
- rst  input  1  synchronous, active-high reset.
- reqValid  input  1  report request strobe.
- reqType  input  ReportType_t  REPORT_CPR, REPORT_DA, REPORT_OK, REPORT_KEY_UP, REPORT_KEY_DOWN, REPORT_KEY_RIGHT or REPORT_KEY_LEFT.
- reqRow  input  COORD_WIDTH  cursor row, 0-based; used only for REPORT_CPR.
- reqCol  input  COORD_WIDTH  cursor column, 0-based; used only for REPORT_CPR.
- reqReady  output  1  a request is accepted when reqValid && reqReady.
- keyValid  input  1  plain ASCII byte strobe.
- keyData  input  8  ASCII byte.
- keyReady  output  1  a key byte is accepted when keyValid && keyReady.
- txBusy  input  1  busy flag from async_transmitter.
- txStart  output  1  one-cycle send pulse.
- txData  output  8  byte to send; valid while txStart is high.
- active  output  1  high while any sequence or byte is in flight.

Behaviour:
- Reset values: txStart=0, txData=8'h00, reqReady=0, keyReady=0, active=0, FSM=IDLE. Any key FIFO is emptied. In the first cycle after rst deasserts, reqReady=1.
- reqReady=1 only in IDLE.
- keyReady rules:
  - Without the FIFO: keyReady=1 only in IDLE and only when reqValid=0. Reports have priority when both strobes arrive in the same cycle.
  - With the FIFO: see Optional Feature.
- Request capture on acceptance:
  - reqType is latched.
  - row+1 and col+1 are latched, each one bit wider than the input. Reports are 1-based; 127 encodes as "128".
- Byte sequences:
  - CPR: 1B 5B <row digits> 3B <col digits> 52.
  - DA: 1B 5B 3F 31 3B 30 63.
  - OK: 1B 5B 30 6E.
  - Keys: 1B 5B 41 (up), 42 (down), 43 (right), 44 (left).
  - Plain key: the single byte keyData.
- Digit rules: decimal, most significant digit first, no leading zeros, minimum one digit, ASCII 30-39.
- FSM states: IDLE, CONVERT, EMIT, GUARD, WAIT.
  - IDLE: on acceptance, CPR goes to CONVERT; everything else goes to EMIT.
  - CONVERT: the digit sub-module computes hundreds/tens/units for row and column. At most 2x(9+9+1) cycles. Then go to EMIT.
  - EMIT: if txBusy=0, pulse txStart for exactly one cycle with the current byte, then go to GUARD. If txBusy=1, stay in EMIT.
  - GUARD: wait one cycle, ignoring txBusy to cover the transmitter's one-cycle busy latency. Then go to WAIT.
  - WAIT: when txBusy=0, advance the byte index. Go to EMIT if bytes remain, else IDLE.
- Handshake invariants:
  - txStart is never asserted in two consecutive cycles.
  - txStart is never asserted while txBusy=1.
  - txData is held from the txStart cycle until the next EMIT.
- Simultaneous events:
  - reqValid while not IDLE is ignored; upstream must hold it.
  - txBusy stuck high stalls the block in EMIT/WAIT indefinitely. There is no timeout.
- Reset mid-sequence: the next cycle has txStart=0 and state IDLE; the remaining bytes are discarded. A byte already handed to the transmitter still completes on the line.
- active = (state != IDLE) || FIFO non-empty.

Optional Feature:
- VT100_KEY_FIFO_EN defined:
  - Key bytes go into a FIFO_DEPTH-entry queue; keyReady = !full in every state.
  - In IDLE, a pending report is served before queued keys. Keys are sent in arrival order.
  - Simultaneous push and pop while full is not permitted: keyReady=0 while full.
- Not defined: no queue; keyReady follows the IDLE rule above. Keys arriving while busy are refused, and the upstream drops them.

Decomposition:
- Shared package vt100_pkg:
  - ReportType_t enum.
  - Constants ASCII_ESC=8'h1B, ASCII_LBRACKET=8'h5B, ASCII_SEMI=8'h3B.
  - The DA string constant.
- Sub-module vt100_decimal_digits: sequential subtract-by-100/10 converter.
  - start/done handshake.
  - Outputs three BCD digits plus a digit count.
  - Used twice in sequence, for row then column.

Test Plan:
- CPR with reqRow=4, reqCol=11 -> txData sequence 1B 5B 35 3B 31 32 52. Exactly 7 txStart pulses; active=0 afterwards.
- DA request, with txBusy modelled as high for 10 cycles after each start -> 1B 5B 3F 31 3B 30 63. No txStart while busy; no back-to-back pulses.
- CPR with reqRow=127, reqCol=0, then REPORT_KEY_LEFT -> 1B 5B 31 32 38 3B 31 52, then 1B 5B 44.
- keyValid and reqValid (REPORT_OK) in the same cycle, FIFO off -> keyReady=0 that cycle; only 1B 5B 30 6E is sent.
- FIFO on: four keys 61 62 63 64 pushed during a CPR -> CPR bytes first, then 61 62 63 64. A fifth push while full sees keyReady=0.
- rst asserted after the 3rd byte of a DA -> txStart=0 and reqReady=0 in the reset cycle, reqReady=1 the cycle after release. No further DA bytes are emitted.
